// File: rtl/hft_rx_pkg.sv
// Shared receive-side definitions: frame geometry, default sync marker, field widths and deframer states.
// Field widths must stay in step with the transmit mux so both ends agree on the wire format.
package hft_rx_pkg;

    localparam int         FRAME_LEN         = 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam int ADDR_W = 8;
    localparam int BS_W   = 8;
    localparam int TS_W   = 32;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        BS,
        TS,
        CHK
    } rx_state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap watchdog: counts idle cycles while enabled, expire is combinational in the last allowed cycle.
// A clear in the expiry cycle suppresses expire, so a late byte still beats the timeout.
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rx_frame_decoder.sv
// Deframes SYNC/ADDR/BUYSELL/TS[4]/CHK byte frames from the UART rx into registered fields with an XOR check.
// rx_dv/frame_err pulse one cycle after the CHK byte is sampled; no backpressure, a byte is accepted every cycle.
module rx_frame_decoder
    import hft_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_byte_dv,
    output logic [ADDR_W-1:0]    rx_addr,
    output logic [BS_W-1:0]      rx_buysell,
    output logic [TS_W-1:0]      rx_timestamp,
    output logic                 rx_dv,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    rx_state_t       state;
    rx_state_t       state_nxt;
    logic [1:0]      ts_idx;
    logic [7:0]      xor_acc;
    logic [ADDR_W-1:0] addr_sh;
    logic [BS_W-1:0]   bs_sh;
    logic [TS_W-1:0]   ts_sh;
    logic            good_q;
    logic            bad_q;
    logic            expire;
    logic            timer_en;

    logic            clr_xor;
    logic            take_addr;
    logic            take_bs;
    logic            take_ts;
    logic            chk_seen;
    logic            chk_match;

    assign timer_en  = (state != HUNT);
    assign busy      = (state != HUNT);
    assign chk_match = (rx_byte == xor_acc);

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (reset_n),
        .clear (rx_byte_dv),
        .enable(timer_en),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (expire) begin
            state_nxt = HUNT;
        end else if (rx_byte_dv) begin
            case (state)
                HUNT:    if (rx_byte == SYNC_BYTE) state_nxt = ADDR;
                ADDR:    state_nxt = BS;
                BS:      state_nxt = TS;
                TS:      if (ts_idx == 2'd3) state_nxt = CHK;
                CHK:     state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        clr_xor   = 1'b0;
        take_addr = 1'b0;
        take_bs   = 1'b0;
        take_ts   = 1'b0;
        chk_seen  = 1'b0;
        if (rx_byte_dv) begin
            case (state)
                HUNT:    clr_xor   = (rx_byte == SYNC_BYTE);
                ADDR:    take_addr = 1'b1;
                BS:      take_bs   = 1'b1;
                TS:      take_ts   = 1'b1;
                CHK:     chk_seen  = 1'b1;
                default: clr_xor   = 1'b0;
            endcase
        end
    end

    // Shadow fields; ts_idx restarts on every SYNC so a timed-out TS phase cannot leak into the next frame.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ts_idx  <= 2'd0;
            xor_acc <= 8'h00;
            addr_sh <= '0;
            bs_sh   <= '0;
            ts_sh   <= '0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            good_q <= chk_seen && chk_match;
            bad_q  <= chk_seen && !chk_match;
            if (clr_xor) begin
                xor_acc <= 8'h00;
                ts_idx  <= 2'd0;
            end
            if (take_addr || take_bs || take_ts) begin
                xor_acc <= xor_acc ^ rx_byte;
            end
            if (take_addr) addr_sh <= rx_byte;
            if (take_bs)   bs_sh   <= rx_byte;
            if (take_ts) begin
                ts_sh  <= {ts_sh[TS_W-9:0], rx_byte};
                ts_idx <= ts_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rx_addr      <= '0;
            rx_buysell   <= '0;
            rx_timestamp <= '0;
            rx_dv        <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            rx_dv     <= good_q;
            frame_err <= bad_q || expire;
            if (good_q) begin
                rx_addr      <= addr_sh;
                rx_buysell   <= bs_sh;
                rx_timestamp <= ts_sh;
            end
            if ((bad_q || expire) && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/rx_frame_decoder.md
Name: rx_frame_decoder

Overview:
Receive-side counterpart of the order transmit path. Takes the byte stream from the UART receiver and deframes fixed-length messages into addr, buysell and timestamp fields. Delivers each checked message to downstream logic as a one-cycle valid pulse. Sits between the UART rx core and the strategy/system blocks, mirroring the tx mux-to-UART path.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between bytes inside a frame.
ERR_CNT_W, 16, width of the saturating error counter.

Ports:
clk  in  1  system clock; all logic on posedge.
reset_n  in  1  asynchronous, active-high reset; asserted value 1 resets the block (port name kept for codebase consistency).
rx_byte  in  8  byte from UART rx; valid only when rx_byte_dv=1.
rx_byte_dv  in  1  one-cycle strobe per received byte.
rx_addr  out  8  address field of last good frame.
rx_buysell  out  8  buy/sell field of last good frame.
rx_timestamp  out  32  timestamp of last good frame, big-endian on the wire.
rx_dv  out  1  one-cycle pulse: fields above updated with a new good frame.
frame_err  out  1  one-cycle pulse on checksum failure or inter-byte timeout.
err_count  out  ERR_CNT_W  saturating count of frame_err pulses.
busy  out  1  high whenever the state is not HUNT.

Behaviour:
- Frame on wire, 8 bytes: SYNC, ADDR, BUYSELL, TS[31:24], TS[23:16], TS[15:8], TS[7:0], CHK.
- CHK is the XOR of bytes 2-7 (ADDR through TS[7:0]); SYNC is excluded.
- Reset values: all outputs 0, state HUNT, shadow registers 0, running XOR 0, timer 0.
- States: HUNT, ADDR, BS, TS (2-bit byte index 0..3), CHK.
- Transitions advance only on rx_byte_dv.
- HUNT: a byte equal to SYNC_BYTE moves to ADDR and clears the running XOR. Any other byte is ignored.
- ADDR / BS / TS: latch the byte into a shadow register, XOR it into the running XOR, then advance. TS moves to CHK after index 3.
- Inside a frame, a SYNC_BYTE value is plain data; there is no mid-frame resync.
- CHK match: copy shadow registers to the rx_* outputs and pulse rx_dv. Return to HUNT.
- CHK mismatch: rx_* outputs are unchanged. Pulse frame_err, increment err_count, return to HUNT.
- Latency: rx_dv or frame_err rises on the clk edge after the edge that sampled the CHK byte, and lasts exactly one cycle.
- rx_* outputs hold their value until the next good frame.
- Back-to-back frames with zero idle cycles are supported. A SYNC byte arriving the cycle after CHK is accepted.
- Timeout: a counter clears on every rx_byte_dv and increments each cycle while state is not HUNT.
- On reaching TIMEOUT_CYCLES-1 with no byte that cycle: pulse frame_err, increment err_count, go to HUNT, discard the partial frame.
- Timeout vs byte: if a byte arrives in the expiry cycle, the byte wins and the counter clears.
- The counter is held at 0 in HUNT.
- err_count saturates at all-ones and does not wrap.
- Reset mid-frame: the partial frame is discarded, with no rx_dv and no frame_err.
- rx_dv and frame_err are never high in the same cycle.

Decomposition:
- Shared package hft_rx_pkg holds:
  - FRAME_LEN=8;
  - default SYNC_BYTE;
  - state enum {HUNT, ADDR, BS, TS, CHK};
  - field width constants ADDR_W=8, BS_W=8, TS_W=32, shared with tx_mux.
- One sub-module: rx_gap_timer.
  - Inputs: clear, enable.
  - Output: expire.
  - Parameter: TIMEOUT_CYCLES; counter width $clog2(TIMEOUT_CYCLES).
- The FSM, XOR accumulator and output registers stay in rx_frame_decoder.

Test Plan:
- Good frame, byte stream A5 03 01 12 34 56 78 0A -> one rx_dv pulse, then rx_addr=03, rx_buysell=01, rx_timestamp=12345678; frame_err stays 0.
- Same frame with CHK=0B -> frame_err pulse, err_count=1, no rx_dv, rx_* keep their prior values.
- Garbage 00 FF 5A before a good frame -> ignored; the frame decodes normally and busy rises only after A5.
- Frame cut after TS[15:8] with TIMEOUT_CYCLES=16 and no further bytes -> frame_err 16 cycles after the last byte, then a following good frame decodes correctly.
- Two good frames back-to-back, the second being A5 07 00 00 00 00 FF F8 -> two rx_dv pulses 8 byte-strobes apart; final rx_addr=07, rx_timestamp=000000FF.
- Force 65537 checksum errors with ERR_CNT_W=16 -> err_count stays at FFFF.
- Assert reset_n after the ADDR byte -> no pulse on either rx_dv or frame_err, outputs go to 0, and the next good frame decodes correctly.
